// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812B chain controller: bit timing, FSM
// state encoding and the GRB pixel type.
package ws2812_pkg;

  localparam int unsigned T0H = 9;
  localparam int unsigned T0L = 22;
  localparam int unsigned T1H = 19;
  localparam int unsigned T1L = 16;
  localparam int unsigned RES = 1350;

  // Cycle counter width, large enough for RES-1
  localparam int unsigned CW  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  typedef logic [23:0] pixel_t;

endpackage

// File: rtl/ws2812_bit_tx.sv
// 24-bit MSB-first WS2812 bit serializer. A pixel is accepted on
// pix_valid & pix_ready; ready is high while idle and in the last cycle of
// bit 0, so back-to-back pixels stream with no gap. dout is registered.
module ws2812_bit_tx #(
  parameter int unsigned T0H = 9,
  parameter int unsigned T0L = 22,
  parameter int unsigned T1H = 19,
  parameter int unsigned T1L = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        dout
);
  import ws2812_pkg::*;

  logic          active;
  pixel_t        shreg;
  logic [4:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] bit_high;
  logic [CW-1:0] bit_len;
  logic          last_cyc;
  logic          load;

  // Shape of the bit currently on the line and handshake decode
  always_comb begin
    bit_high  = shreg[23] ? CW'(T1H) : CW'(T0H);
    bit_len   = shreg[23] ? CW'(T1H + T1L) : CW'(T0H + T0L);
    last_cyc  = (cnt == bit_len - 1'b1);
    pix_ready = !active || (bit_idx == 5'd0 && last_cyc);
    load      = pix_valid && pix_ready;
  end

  // Shift register, bit/cycle counters; dout is set one cycle ahead so the
  // registered output lines up with cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      dout    <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      shreg   <= pix_data;
      bit_idx <= 5'd23;
      cnt     <= '0;
      dout    <= 1'b1;
    end else if (active) begin
      if (last_cyc) begin
        if (bit_idx == 5'd0) begin
          active <= 1'b0;
          dout   <= 1'b0;
        end else begin
          shreg   <= shreg << 1;
          bit_idx <= bit_idx - 1'b1;
          cnt     <= '0;
          dout    <= 1'b1;
        end
      end else begin
        cnt  <= cnt + 1'b1;
        dout <= (cnt + 1'b1) < bit_high;
      end
    end
  end

endmodule

// File: rtl/ws2812_chain_ctrl.sv
// WS2812B chain frame sequencer: pixel buffer, IDLE/LOAD/SEND/LATCH FSM,
// one-deep start pending flag. Optional periodic refresh is built when
// WS2812_CTRL_AUTO_REFRESH_EN is defined.
module ws2812_chain_ctrl #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned T0H      = ws2812_pkg::T0H,
  parameter int unsigned T0L      = ws2812_pkg::T0L,
  parameter int unsigned T1H      = ws2812_pkg::T1H,
  parameter int unsigned T1L      = ws2812_pkg::T1L,
  parameter int unsigned RES      = ws2812_pkg::RES
`ifdef WS2812_CTRL_AUTO_REFRESH_EN
  ,
  parameter int unsigned REFRESH_CYCLES = 540000
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic          dout
);
  import ws2812_pkg::*;

  state_t        state, state_n;
  pixel_t        pix_buf [2**AW];
  logic [AW-1:0] idx;
  logic          last_pix;
  logic          pending;
  logic [CW-1:0] lat_cnt;
  logic          pix_valid;
  logic          pix_ready;
  pixel_t        pix_data;
  logic          hs;
  logic          go;
  logic          refresh_tick;

  // Host writes land every cycle; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(NUM_LEDS)))
      pix_buf[wr_addr] <= wr_data;
  end

  assign pix_data = pix_buf[idx];
  assign hs       = pix_valid && pix_ready;
  assign busy     = (state != IDLE);

  // Next-state, pixel offer to the serializer and frame_done decode
  always_comb begin
    state_n    = state;
    pix_valid  = 1'b0;
    frame_done = 1'b0;
    go         = 1'b0;
    case (state)
      IDLE: begin
        if (start || pending) begin
          go      = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        pix_valid = 1'b1;
        if (pix_ready) state_n = SEND;
      end
      SEND: begin
        // Next pixel is offered while the current one plays; the serializer
        // takes it in the last cycle of bit 0
        pix_valid = !last_pix;
        if (pix_ready && last_pix) state_n = LATCH;
      end
      LATCH: begin
        if (lat_cnt == CW'(RES - 1)) begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pixel index, latch counter and pending request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      last_pix <= 1'b0;
      lat_cnt  <= '0;
      pending  <= 1'b0;
    end else begin
      state <= state_n;
      if (go)
        idx <= '0;
      else if (hs)
        idx <= idx + 1'b1;
      if (hs)
        last_pix <= (idx == AW'(NUM_LEDS - 1));
      if (state == LATCH)
        lat_cnt <= lat_cnt + 1'b1;
      else
        lat_cnt <= '0;
      if (go)
        pending <= 1'b0;
      else if ((start && state != IDLE) || refresh_tick)
        pending <= 1'b1;
    end
  end

`ifdef WS2812_CTRL_AUTO_REFRESH_EN
  localparam int unsigned RW = $clog2(REFRESH_CYCLES);
  logic [RW-1:0] ref_cnt;

  assign refresh_tick = (ref_cnt == RW'(REFRESH_CYCLES - 1));

  // Free-running refresh period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ref_cnt <= '0;
    else if (refresh_tick)
      ref_cnt <= '0;
    else
      ref_cnt <= ref_cnt + 1'b1;
  end
`else
  assign refresh_tick = 1'b0;
`endif

  ws2812_bit_tx #(
    .T0H (T0H),
    .T0L (T0L),
    .T1H (T1H),
    .T1L (T1L)
  ) u_bit_tx (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .dout      (dout)
  );

endmodule

// File: tb/tb_ws2812_chain_ctrl.sv
// Self-checking bench for ws2812_chain_ctrl: dout is decoded bit by bit
// against a queue of expected pixels, busy length against expected frame
// lengths, plus directed latency, pending, write and reset checks.
module tb_ws2812_chain_ctrl;

  localparam int NL   = 6;
  localparam int TAW  = 4;
  localparam int P0H  = 9;
  localparam int P0L  = 22;
  localparam int P1H  = 19;
  localparam int P1L  = 16;
  localparam int PRES = 1350;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [TAW-1:0] wr_addr = '0;
  logic [23:0]    wr_data = '0;
  logic           start = 1'b0;
  logic           busy;
  logic           frame_done;
  logic           dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] model [NL];
  logic [23:0] exp_pix [$];
  int          exp_len [$];

  ws2812_chain_ctrl #(
    .NUM_LEDS (NL),
    .AW       (TAW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int bitlen(input logic b);
    return b ? (P1H + P1L) : (P0H + P0L);
  endfunction

  function automatic int bits_prefix(input logic [23:0] p, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += bitlen(p[23 - i]);
    return s;
  endfunction

  function automatic int framelen();
    int s = PRES + 1;
    for (int i = 0; i < NL; i++) s += bits_prefix(model[i], 24);
    return s;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < NL; i++) exp_pix.push_back(model[i]);
    exp_len.push_back(framelen());
  endtask

  task automatic write_pix(input logic [TAW-1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (int'(a) < NL) model[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fd();
    bit seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_timeout", 32'(seen), 32'd1);
  endtask

  // Serial decoder: high/low run lengths per bit against the expected pixel stream
  int          hcnt, lcnt, nbits, exp_low;
  logic        prev_d;
  logic [23:0] acc, fp;
  always @(negedge clk) begin
    if (rst) begin
      hcnt = 0; lcnt = 0; nbits = 0; exp_low = 0; prev_d = 1'b0; acc = '0;
    end else begin
      if (dout) begin
        if (!prev_d) begin
          if (nbits % (NL * 24) != 0) check("bit_low", 32'(lcnt), 32'(exp_low));
          hcnt = 1;
        end else begin
          hcnt++;
        end
      end else begin
        if (prev_d) begin
          if (exp_pix.size() == 0) begin
            check("pix_unexpected", 32'd1, 32'd0);
          end else begin
            fp = exp_pix[0];
            check("bit_high", 32'(hcnt), fp[23 - (nbits % 24)] ? 32'(P1H) : 32'(P0H));
            exp_low = fp[23 - (nbits % 24)] ? P1L : P0L;
            acc = {acc[22:0], (hcnt == P1H)};
            nbits++;
            if (nbits % 24 == 0) check("pixel", 32'(acc), 32'(exp_pix.pop_front()));
          end
          lcnt = 1;
        end else begin
          lcnt++;
        end
      end
      prev_d = dout;
    end
  end

  // Busy-run monitor: run length per frame and frame_done in its last cycle
  int   bcnt;
  logic pb, pfd;
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0; pb = 1'b0; pfd = 1'b0;
    end else begin
      if (busy) begin
        bcnt++;
      end else if (pb) begin
        if (exp_len.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
        else check("busy_len", 32'(bcnt), 32'(exp_len.pop_front()));
        check("fd_last_cycle", 32'(pfd), 32'd1);
        bcnt = 0;
      end
      pb  = busy;
      pfd = frame_done;
    end
  end

  initial begin
    int highs;
    for (int i = 0; i < NL; i++) model[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: all zeros, with start latency checks
    for (int i = 0; i < NL; i++) write_pix(TAW'(i), 24'h000000);
    check("zero_frame_len", 32'(framelen()), 32'(NL * 24 * 31 + 1351));
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_dout_load", 32'(dout), 32'd0);
    @(posedge clk); #1;
    check("lat_dout", 32'(dout), 32'd1);
    wait_fd();
    @(posedge clk); #1;
    check("idle_after_f1", 32'(busy), 32'd0);

    // Frame 2: mixed patterns; mid-frame writes and double start
    write_pix(4'd0, 24'hFF0000);
    write_pix(4'd1, 24'h000000);
    write_pix(4'd2, 24'hA5A5A5);
    write_pix(4'd3, 24'h123456);
    write_pix(4'd4, 24'hFFFFFF);
    write_pix(4'd5, 24'h0F0F0F);
    push_frame();
    pulse_start();
    begin
      int off = 1 + 10;
      for (int i = 0; i < 5; i++) off += bits_prefix(model[i], 24);
      repeat (off) @(posedge clk);
      #1;
    end
    write_pix(4'd3, 24'h00FF00);
    write_pix(4'd9, 24'hFFFFFF);
    write_pix(4'd6, 24'hFFFFFF);
    pulse_start();
    @(posedge clk); #1;
    pulse_start();
    push_frame();
    wait_fd();
    @(posedge clk); #1;
    check("gap_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("pending_load", 32'(busy), 32'd1);
    wait_fd();
    repeat (40) @(posedge clk);
    #1;
    check("no_extra_frame", 32'(busy), 32'd0);
    check("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
    check("len_queue_empty", 32'(exp_len.size()), 32'd0);

    // Frame 4 aborted by reset in bit 10 of pixel 2, then a full frame
    push_frame();
    pulse_start();
    repeat (1 + bits_prefix(model[0], 24) + bits_prefix(model[1], 24) + bits_prefix(model[2], 10) + 5)
      @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_pix.delete();
    exp_len.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    push_frame();
    pulse_start();
    wait_fd();
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_pix_empty", 32'(exp_pix.size()), 32'd0);
    check("post_rst_len_empty", 32'(exp_len.size()), 32'd0);

`ifndef WS2812_CTRL_AUTO_REFRESH_EN
    // No start and no refresh: the line must stay low
    highs = 0;
    repeat (3000) begin
      @(posedge clk); #1;
      if (dout || busy) highs++;
    end
    check("idle_line_low", 32'(highs), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
